// File: rtl/full_subtractor_pkg.sv
// Shared types and constants for the ripple-borrow subtractor and its bench.
package full_subtractor_pkg;

  typedef struct packed {
    logic minuend;
    logic subtrahend;
    logic borrow_in;
    logic diff;
    logic borrow_out;
  } fs_vector_t;

  localparam int FS_TT_N = 8;

  // Golden 1-bit cell behaviour, indexed by {minuend, subtrahend, borrow_in}.
  localparam fs_vector_t FS_TRUTH_TABLE [0:FS_TT_N-1] = '{
    5'b000_00,
    5'b001_11,
    5'b010_11,
    5'b011_01,
    5'b100_10,
    5'b101_00,
    5'b110_00,
    5'b111_11
  };

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor cell: difference and borrow out from a, b and borrow in.
module full_subtractor_cell
  import full_subtractor_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic d_o,
  output logic c_o
);

  assign d_o = a_i ^ b_i ^ c_i;
  assign c_o = (~a_i & b_i) | (~a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/full_subtractor.sv
// Ripple-borrow subtractor with combinational result, one registered copy and a
// saturating count of valid operations that borrowed out of the MSB.
module full_subtractor
  import full_subtractor_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             borrow_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic [WIDTH-1:0] diff_q,
  output logic             borrow_out_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] borrow_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH:0]   brw;
  logic [CNT_W-1:0] cnt_d;

  assign brw[0] = borrow_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_subtractor_cell u_cell (
      .a_i (minuend[i]),
      .b_i (subtrahend[i]),
      .c_i (brw[i]),
      .d_o (diff[i]),
      .c_o (brw[i+1])
    );
  end

  assign borrow_out = brw[WIDTH];

  // Counter holds at all-ones instead of wrapping.
  always_comb begin
    cnt_d = borrow_cnt;
    if (borrow_out && (borrow_cnt != CNT_MAX)) begin
      cnt_d = borrow_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      out_valid    <= 1'b0;
      borrow_cnt   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff_q       <= diff;
        borrow_out_q <= borrow_out;
        borrow_cnt   <= cnt_d;
      end
    end
  end

endmodule

// File: tb/tb_full_subtractor.sv
// Directed and random checks of the subtractor across several parameterisations.
module tb_full_subtractor;
  import full_subtractor_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic rst;

  // WIDTH=1
  logic a1, b1, bi1, v1, d1, bo1, d1q, bo1q, ov1;
  logic [7:0] c1;
  // WIDTH=8, CNT_W=8
  logic [7:0] a8, b8, d8, d8q, c8;
  logic bi8, v8, bo8, bo8q, ov8;
  // WIDTH=8, CNT_W=2
  logic [7:0] as2, bs2, ds2, ds2q;
  logic bis2, vs2, bos2, bos2q, ovs2;
  logic [1:0] cs2;
  // WIDTH=16, CNT_W=8
  logic [15:0] a16, b16, d16, d16q;
  logic bi16, v16, bo16, bo16q, ov16;
  logic [7:0] c16;

  full_subtractor #(.WIDTH(1), .CNT_W(8)) u_w1 (
    .clk(clk), .rst(rst), .minuend(a1), .subtrahend(b1), .borrow_in(bi1),
    .in_valid(v1), .diff(d1), .borrow_out(bo1), .diff_q(d1q),
    .borrow_out_q(bo1q), .out_valid(ov1), .borrow_cnt(c1));

  full_subtractor #(.WIDTH(8), .CNT_W(8)) u_w8 (
    .clk(clk), .rst(rst), .minuend(a8), .subtrahend(b8), .borrow_in(bi8),
    .in_valid(v8), .diff(d8), .borrow_out(bo8), .diff_q(d8q),
    .borrow_out_q(bo8q), .out_valid(ov8), .borrow_cnt(c8));

  full_subtractor #(.WIDTH(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .minuend(as2), .subtrahend(bs2), .borrow_in(bis2),
    .in_valid(vs2), .diff(ds2), .borrow_out(bos2), .diff_q(ds2q),
    .borrow_out_q(bos2q), .out_valid(ovs2), .borrow_cnt(cs2));

  full_subtractor #(.WIDTH(16), .CNT_W(8)) u_w16 (
    .clk(clk), .rst(rst), .minuend(a16), .subtrahend(b16), .borrow_in(bi16),
    .in_valid(v16), .diff(d16), .borrow_out(bo16), .diff_q(d16q),
    .borrow_out_q(bo16q), .out_valid(ov16), .borrow_cnt(c16));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {diff, borrow_out} for the 1-bit cell, indexed by {a, b, bin}.
  logic [1:0] exp1 [0:7] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

  logic [8:0]  sb8  [$];
  logic [16:0] sb16 [$];
  logic [16:0] ref17, e17;
  logic [8:0]  e9;
  logic [7:0]  cnt_m;
  logic        v_prev;
  logic [1:0]  sat_exp [0:4] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    rst = 1'b1;
    a1 = 0; b1 = 0; bi1 = 0; v1 = 0;
    a8 = 0; b8 = 0; bi8 = 0; v8 = 0;
    as2 = 0; bs2 = 0; bis2 = 0; vs2 = 0;
    a16 = 0; b16 = 0; bi16 = 0; v16 = 0;

    // Reset for two cycles: every registered output cleared.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w1", {c1, ov1, bo1q, d1q}, 32'h0);
    chk("rst_w8_dq", d8q, 32'h0);
    chk("rst_w8_boq", bo8q, 32'h0);
    chk("rst_w8_ov", ov8, 32'h0);
    chk("rst_w8_cnt", c8, 32'h0);
    chk("rst_sat", {cs2, ovs2, bos2q, ds2q}, 32'h0);
    chk("rst_w16", {c16, ov16, bo16q, d16q}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // WIDTH=1 exhaustive truth table, combinational.
    for (int i = 0; i < FS_TT_N; i++) begin
      a1  = FS_TRUTH_TABLE[i].minuend;
      b1  = FS_TRUTH_TABLE[i].subtrahend;
      bi1 = FS_TRUTH_TABLE[i].borrow_in;
      #1;
      chk($sformatf("w1_diff_%0d", i), d1, exp1[{a1, b1, bi1}][1]);
      chk($sformatf("w1_bout_%0d", i), bo1, exp1[{a1, b1, bi1}][0]);
    end

    // WIDTH=8 boundaries, combinational.
    a8 = 8'h00; b8 = 8'hFF; bi8 = 1'b1; #1;
    chk("w8_0_ff_1", {bo8, d8}, {23'd0, 1'b1, 8'h00});
    a8 = 8'h5A; b8 = 8'h5A; bi8 = 1'b1; #1;
    chk("w8_eq_1", {bo8, d8}, {23'd0, 1'b1, 8'hFF});
    a8 = 8'h5A; b8 = 8'h5A; bi8 = 1'b0; #1;
    chk("w8_eq_0", {bo8, d8}, {23'd0, 1'b0, 8'h00});
    a8 = 8'h80; b8 = 8'h01; bi8 = 1'b0; #1;
    chk("w8_80_01", {bo8, d8}, {23'd0, 1'b0, 8'h7F});

    // Registered stage: 3 - 5 lands one edge later.
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd5; bi8 = 1'b0; v8 = 1'b1;
    sb8.push_back({1'b1, 8'hFE});
    @(posedge clk); #1;
    chk("reg_ov1", ov8, 32'h1);
    e9 = sb8.pop_front();
    chk("reg_dq", d8q, e9[7:0]);
    chk("reg_boq", bo8q, e9[8]);
    chk("reg_cnt1", c8, 32'h1);
    @(negedge clk);
    v8 = 1'b0; a8 = 8'h10; b8 = 8'h01;
    @(posedge clk); #1;
    chk("reg_ov0", ov8, 32'h0);
    chk("reg_dq_hold", d8q, 32'hFE);
    chk("reg_boq_hold", bo8q, 32'h1);
    chk("reg_cnt_hold", c8, 32'h1);

    // Counter saturation at CNT_W=2.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      as2 = 8'd0; bs2 = 8'd1; bis2 = 1'b0; vs2 = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("sat_cnt_%0d", i), cs2, sat_exp[i]);
    end
    // A valid op coinciding with reset is dropped.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("sat_rst_cnt", cs2, 32'h0);
    chk("sat_rst_ov", ovs2, 32'h0);
    chk("rst_comb_live", {bos2, ds2}, {23'd0, 1'b1, 8'hFF});
    @(negedge clk);
    rst = 1'b0; vs2 = 1'b0;

    // Random WIDTH=16 against a 17-bit reference, with scoreboard on the registered copy.
    cnt_m = 8'd0;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      a16  = 16'($urandom);
      b16  = 16'($urandom);
      bi16 = 1'($urandom);
      v16  = ($urandom_range(0, 3) != 0);
      v_prev = v16;
      #1;
      ref17 = {1'b0, a16} - {1'b0, b16} - 17'(bi16);
      chk("rnd_comb", {bo16, d16}, 32'(ref17));
      if (v16) begin
        sb16.push_back(ref17);
        if (ref17[16] && cnt_m != 8'hFF) cnt_m = cnt_m + 8'd1;
      end
      @(posedge clk); #1;
      chk("rnd_ov", ov16, v_prev);
      chk("rnd_cnt", c16, cnt_m);
      if (ov16) begin
        if (sb16.size() == 0) begin
          chk("rnd_sb_empty", 32'(sb16.size()), 32'h1);
        end else begin
          e17 = sb16.pop_front();
          chk("rnd_reg", {bo16q, d16q}, 32'(e17));
        end
      end
    end
    chk("rnd_sb_drained", 32'(sb16.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/full_subtractor.md
Name: full_subtractor

Overview:
- Parameterised ripple-borrow subtractor computing minuend − subtrahend − borrow_in.
- Combinational result outputs, plus a one-stage registered copy with valid flag and a saturating borrow-event counter for status/debug.
- Leaf arithmetic block used by datapath ALUs.
- At WIDTH=1 the combinational outputs are exactly the classic 1-bit full subtractor.

Parameters:
- WIDTH, 1, operand/difference bit width (≥1).
- CNT_W, 8, width of borrow-event counter (≥1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- minuend  input  WIDTH  operand A
- subtrahend  input  WIDTH  operand B
- borrow_in  input  1  borrow into bit 0
- in_valid  input  1  qualifies operands for the registered stage
- diff  output  WIDTH  combinational A − B − borrow_in (mod 2^WIDTH)
- borrow_out  output  1  combinational borrow out of MSB
- diff_q  output  WIDTH  registered diff
- borrow_out_q  output  1  registered borrow_out
- out_valid  output  1  registered in_valid
- borrow_cnt  output  CNT_W  saturating count of valid operations that produced borrow_out=1

Behaviour:
- Per bit i: d_i = a_i ^ b_i ^ c_i; c_{i+1} = (~a_i & b_i) | (~a_i & c_i) | (b_i & c_i).
- c_0 = borrow_in; diff[i] = d_i; borrow_out = c_WIDTH.
- Equivalent: {borrow_out, diff} = {1'b0, A} − {1'b0, B} − borrow_in, taken in WIDTH+1 bits. borrow_out=1 iff A < B + borrow_in.
- diff/borrow_out: purely combinational, zero latency, independent of clk/rst, no X when inputs are known. They settle within the same delta/timestep as an input change.
- Registered stage, on each rising clk edge:
  - if rst: diff_q=0, borrow_out_q=0, out_valid=0, borrow_cnt=0.
  - else: out_valid<=in_valid.
  - If in_valid: diff_q<=diff, borrow_out_q<=borrow_out, and if borrow_out then borrow_cnt<=borrow_cnt+1, saturating at 2^CNT_W−1 (holds, no wrap).
  - If !in_valid: diff_q/borrow_out_q hold their previous values.
- Latency of registered stage: 1 cycle. No backpressure; a new operation is accepted every cycle.
- Reset mid-operation: a valid accepted in the same cycle as rst is discarded. Combinational outputs are unaffected by rst.
- Boundaries:
  - A=0, B=all-ones, borrow_in=1 → diff=0, borrow_out=1.
  - A=B, borrow_in=0 → diff=0, borrow_out=0.
  - A=B, borrow_in=1 → diff=all-ones, borrow_out=1.

Decomposition:
- Package full_subtractor_pkg:
  - packed struct fs_vector_t {minuend, subtrahend, borrow_in, diff, borrow_out} (1-bit fields).
  - constant 8-entry golden truth table for the 1-bit cell, shared with the verification bench.
- Sub-module full_subtractor_cell: 1-bit combinational cell with the equations above, instantiated WIDTH times via generate, borrow rippled LSB→MSB.
- Top full_subtractor adds the register stage and counter.

Test Plan:
- WIDTH=1 exhaustive, 8 vectors {a,b,bin}→{diff,bout}:
  - 000→00, 001→11, 010→11, 011→01
  - 100→10, 101→00, 110→00, 111→11
  - Check combinational outputs 1 ns after each apply.
- WIDTH=8, A=0x00, B=0xFF, bin=1 → diff=0x00, bout=1. A=0x5A, B=0x5A, bin=1 → diff=0xFF, bout=1. A=0x80, B=0x01, bin=0 → diff=0x7F, bout=0.
- Registered stage: rst 2 cycles → all registered outputs 0. Apply in_valid=1 with A=3, B=5 → next edge diff_q=0xFE (WIDTH=8), borrow_out_q=1, out_valid=1, borrow_cnt=1. Then in_valid=0 → out_valid=0, diff_q holds 0xFE.
- Counter saturation, CNT_W=2: five consecutive valid borrowing ops → borrow_cnt 1,2,3,3,3. Assert rst concurrently with a valid borrowing op → borrow_cnt=0, out_valid=0 on that edge.
- Random WIDTH=16, 10k vectors: combinational and registered outputs match reference {bout,diff} = A−B−bin in 17 bits.
